// File: rtl/proc_mc.sv
// ---------------------------------------------------------------------------
// proc_mc
//   Multi-cycle 16-bit-instruction test processor. Each instruction is first
//   fetched over a request/acknowledge port and then executed in a single
//   EXEC cycle. The processor has an 8-entry register file of width DW and a
//   program counter of width AW. HALT and illegal opcodes are terminal states
//   that hold until reset.
//
// Parameters
//   DW  data/register width, 8..32 (immediates sign-extend to DW)
//   AW  PC / instruction address width, 8..32
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   imem_req    fetch request (high only while fetching)
//   imem_addr   fetch address, always the current PC
//   imem_ack    memory accepted the request; imem_rdata valid same cycle
//   imem_rdata  instruction word
//   retire      one-cycle pulse while a legal instruction executes
//   retire_pc   PC of the retiring instruction
//   halted      sticky, HALT has executed
//   err         sticky, an illegal opcode was decoded
// ---------------------------------------------------------------------------
module proc_mc #(
  parameter int DW = 16,
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [15:0]   imem_rdata,
  output logic          retire,
  output logic [AW-1:0] retire_pc,
  output logic          halted,
  output logic          err
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2,
    ERR   = 2'd3
  } state_t;

  localparam logic [4:0] OP_HALT  = 5'b00000;
  localparam logic [4:0] OP_NOP   = 5'b00001;
  localparam logic [4:0] OP_ADDI  = 5'b01000;
  localparam logic [4:0] OP_XORI  = 5'b01010;
  localparam logic [4:0] OP_BEQZ  = 5'b01100;
  localparam logic [4:0] OP_BNEZ  = 5'b01101;
  localparam logic [4:0] OP_BLTZ  = 5'b01110;
  localparam logic [4:0] OP_BGEZ  = 5'b01111;
  localparam logic [4:0] OP_RTYPE = 5'b11011;

  // Architectural state
  state_t        state;
  logic [AW-1:0] pc;
  logic [15:0]   ir;
  logic [DW-1:0] rf [8];

  // Registered outputs
  logic          req_q;
  logic          retire_q;
  logic [AW-1:0] retire_pc_q;
  logic          halted_q;
  logic          err_q;

  // True for every opcode the processor implements. Used at fetch time so the
  // retire pulse can be registered alongside IR instead of decoded from it.
  function automatic logic op_legal(input logic [4:0] op);
    logic ok;
    case (op)
      OP_HALT, OP_NOP, OP_ADDI, OP_XORI, OP_RTYPE,
      OP_BEQZ, OP_BNEZ, OP_BLTZ, OP_BGEZ: ok = 1'b1;
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Instruction fields
  logic [4:0] op;
  logic [2:0] rs;
  logic [2:0] rt;
  logic [2:0] rd;
  logic [1:0] fn;

  assign op = ir[15:11];
  assign rs = ir[10:8];
  assign rt = ir[7:5];
  assign rd = ir[4:2];
  assign fn = ir[1:0];

  // Operands and immediates. imm8 is sign-extended through a wider temporary
  // so that AW=8 never needs a zero-width replication.
  logic [DW-1:0] rs_val;
  logic [DW-1:0] rt_val;
  logic [DW-1:0] imm5_sext;
  logic [DW-1:0] imm5_zext;
  logic [AW+7:0] imm8_wide;
  logic [AW-1:0] imm8_sext;

  assign rs_val    = rf[rs];
  assign rt_val    = rf[rt];
  assign imm5_sext = {{(DW-5){ir[4]}}, ir[4:0]};
  assign imm5_zext = {{(DW-5){1'b0}}, ir[4:0]};
  assign imm8_wide = {{AW{ir[7]}}, ir[7:0]};
  assign imm8_sext = imm8_wide[AW-1:0];

  // Execute-stage decode: register write, branch decision and the two
  // terminal conditions. Only meaningful while the FSM is in EXEC.
  logic          wr_en;
  logic [2:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic          taken;
  logic          is_halt;
  logic          illegal;

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = rt;
    wr_data = '0;
    taken   = 1'b0;
    is_halt = 1'b0;
    illegal = 1'b0;
    case (op)
      OP_HALT: is_halt = 1'b1;
      OP_NOP:  ;
      OP_ADDI: begin
        wr_en   = 1'b1;
        wr_addr = rt;
        wr_data = rs_val + imm5_sext;
      end
      OP_XORI: begin
        wr_en   = 1'b1;
        wr_addr = rt;
        wr_data = rs_val ^ imm5_zext;
      end
      OP_RTYPE: begin
        wr_en   = 1'b1;
        wr_addr = rd;
        case (fn)
          2'b00:   wr_data = rs_val + rt_val;
          2'b01:   wr_data = rt_val - rs_val;
          2'b10:   wr_data = rs_val ^ rt_val;
          default: wr_data = rs_val & ~rt_val;
        endcase
      end
      OP_BEQZ: taken = (rs_val == '0);
      OP_BNEZ: taken = (rs_val != '0);
      OP_BLTZ: taken = rs_val[DW-1];
      OP_BGEZ: taken = ~rs_val[DW-1];
      default: illegal = 1'b1;
    endcase
  end

  // Next PC wraps naturally at 2^AW.
  logic [AW-1:0] pc_seq;
  logic [AW-1:0] next_pc;

  assign pc_seq  = pc + AW'(2);
  assign next_pc = taken ? pc_seq + imm8_sext : pc_seq;

  // Main FSM. req_q is held low for the first cycle after reset and raised on
  // the first edge, so an acknowledge is only honoured once the request is
  // actually visible on the port. retire is registered on the fetch edge
  // because EXEC always lasts exactly one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= '0;
      ir          <= '0;
      for (int i = 0; i < 8; i++) rf[i] <= '0;
      req_q       <= 1'b0;
      retire_q    <= 1'b0;
      retire_pc_q <= '0;
      halted_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      retire_q <= 1'b0;
      case (state)
        FETCH: begin
          if (req_q && imem_ack) begin
            ir          <= imem_rdata;
            state       <= EXEC;
            req_q       <= 1'b0;
            retire_q    <= op_legal(imem_rdata[15:11]);
            retire_pc_q <= pc;
          end else begin
            req_q <= 1'b1;
          end
        end
        EXEC: begin
          if (illegal) begin
            state <= ERR;
            err_q <= 1'b1;
          end else if (is_halt) begin
            state    <= HALT;
            halted_q <= 1'b1;
          end else begin
            if (wr_en) rf[wr_addr] <= wr_data;
            pc    <= next_pc;
            state <= FETCH;
            req_q <= 1'b1;
          end
        end
        HALT, ERR: ;
        default: ;
      endcase
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc;
  assign retire    = retire_q;
  assign retire_pc = retire_pc_q;
  assign halted    = halted_q;
  assign err       = err_q;

endmodule

// File: tb/tb_proc_mc.sv
// ---------------------------------------------------------------------------
// tb_proc_mc
//   Testbench for proc_mc. Two instances: a default DW=16/AW=16 core and a
//   narrow DW=8/AW=8 core for wrap-around and asynchronous reset behaviour.
//   Instruction memories are word arrays indexed by address bits above bit 0.
// ---------------------------------------------------------------------------
module tb_proc_mc;

  localparam logic [4:0] OP_HALT  = 5'b00000;
  localparam logic [4:0] OP_NOP   = 5'b00001;
  localparam logic [4:0] OP_ADDI  = 5'b01000;
  localparam logic [4:0] OP_XORI  = 5'b01010;
  localparam logic [4:0] OP_BEQZ  = 5'b01100;
  localparam logic [4:0] OP_BNEZ  = 5'b01101;
  localparam logic [4:0] OP_BLTZ  = 5'b01110;
  localparam logic [4:0] OP_BGEZ  = 5'b01111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Wide core
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        retire;
  logic [15:0] retire_pc;
  logic        halted;
  logic        err;
  logic [15:0] mem [0:255];

  assign imem_rdata = mem[imem_addr[8:1]];

  proc_mc #(.DW(16), .AW(16)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .retire(retire), .retire_pc(retire_pc),
    .halted(halted), .err(err)
  );

  // Narrow core
  logic        rst_b;
  logic        req_b;
  logic [7:0]  addr_b;
  logic        ack_b;
  logic [15:0] rdata_b;
  logic        retire_b;
  logic [7:0]  retire_pc_b;
  logic        halted_b;
  logic        err_b;
  logic [15:0] mem_b [0:127];

  assign rdata_b = mem_b[addr_b[7:1]];

  proc_mc #(.DW(8), .AW(8)) dut_b (
    .clk(clk), .rst(rst_b),
    .imem_req(req_b), .imem_addr(addr_b),
    .imem_ack(ack_b), .imem_rdata(rdata_b),
    .retire(retire_b), .retire_pc(retire_pc_b),
    .halted(halted_b), .err(err_b)
  );

  int errors = 0;
  int checks = 0;

  // Instruction encoders
  function automatic logic [15:0] enc_i(input logic [4:0] op, input int rs, input int rt, input int imm);
    return {op, 3'(rs), 3'(rt), 5'(imm)};
  endfunction

  function automatic logic [15:0] enc_r(input int rs, input int rt, input int rd, input int fn);
    return {5'b11011, 3'(rs), 3'(rt), 3'(rd), 2'(fn)};
  endfunction

  function automatic logic [15:0] enc_b(input logic [4:0] op, input int rs, input int imm);
    return {op, 3'(rs), 8'(imm)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  // Leaves the core in "cycle 0": reset just released, no edge seen yet.
  task automatic reset_wide();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic reset_narrow();
    rst_b = 1'b1;
    repeat (2) tick();
    rst_b = 1'b0;
  endtask

  // Reference model: a sequential instruction-set interpreter for the wide core
  logic [15:0] m_r [8];
  logic [15:0] m_pc;
  bit          m_halt;
  bit          m_err;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = 16'h0000;
    m_pc   = 16'h0000;
    m_halt = 1'b0;
    m_err  = 1'b0;
  endtask

  task automatic model_exec();
    logic [15:0] ins;
    logic [15:0] a;
    logic [15:0] b;
    int s, t, d, off, imm5s;
    bit br;
    ins   = mem[m_pc[8:1]];
    s     = int'(ins[10:8]);
    t     = int'(ins[7:5]);
    d     = int'(ins[4:2]);
    off   = $signed(ins[7:0]);
    imm5s = $signed(ins[4:0]);
    a     = m_r[s];
    b     = m_r[t];
    br    = 1'b0;
    case (ins[15:11])
      5'd0:  m_halt = 1'b1;
      5'd1:  ;
      5'd8:  m_r[t] = a + 16'(imm5s);
      5'd10: m_r[t] = a ^ {11'd0, ins[4:0]};
      5'd27: begin
        case (ins[1:0])
          2'd0:    m_r[d] = a + b;
          2'd1:    m_r[d] = b - a;
          2'd2:    m_r[d] = a ^ b;
          default: m_r[d] = a & ~b;
        endcase
      end
      5'd12: br = (a == 16'd0);
      5'd13: br = (a != 16'd0);
      5'd14: br = ($signed(a) < 0);
      5'd15: br = ($signed(a) >= 0);
      default: m_err = 1'b1;
    endcase
    if (!m_halt && !m_err)
      m_pc = br ? m_pc + 16'd2 + 16'(off) : m_pc + 16'd2;
  endtask

  // Random instruction with forward-only branches so every program ends.
  function automatic logic [15:0] rand_instr();
    int r;
    r = $urandom_range(0, 19);
    if (r <= 4)
      return enc_i(OP_ADDI, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 31));
    else if (r <= 7)
      return enc_i(OP_XORI, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 31));
    else if (r <= 12)
      return enc_r($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3));
    else if (r <= 16)
      return enc_b(5'(12 + $urandom_range(0, 3)), $urandom_range(0, 7), 2 * $urandom_range(0, 3));
    else if (r == 17)
      return enc_i(OP_NOP, 0, 0, 0);
    else if (r == 18 && $urandom_range(0, 3) == 0)
      return {5'b10101 + 5'($urandom_range(0, 4)), 11'($urandom)};
    else
      return enc_i(OP_ADDI, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 31));
  endfunction

  // Reset values while reset is held, then first fetch after release
  task automatic test_reset();
    rst = 1'b1;
    imem_ack = 1'b1;
    clear_mem();
    tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b expected 0", imem_req); end
    checks++; if (imem_addr !== 16'h0) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 0000", imem_addr); end
    checks++; if (retire !== 1'b0) begin errors++; $display("[TB] FAIL reset_retire: got %b expected 0", retire); end
    checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL reset_halted: got %b expected 0", halted); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
    rst = 1'b0;
    imem_ack = 1'b0;
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0) begin errors++; $display("[TB] FAIL reset_first_fetch: got req=%b addr=%h expected req=1 addr=0000", imem_req, imem_addr); end
  endtask

  // ADDI R1,R0,5 ; ADDI R2,R1,-3 ; HALT with ack always high
  task automatic test_basic();
    logic exp_ret, exp_req, exp_halt;
    clear_mem();
    mem[0] = enc_i(OP_ADDI, 0, 1, 5);
    mem[1] = enc_i(OP_ADDI, 1, 2, -3);
    mem[2] = enc_i(OP_HALT, 0, 0, 0);
    imem_ack = 1'b1;
    reset_wide();
    for (int c = 1; c <= 10; c++) begin
      tick();
      exp_ret  = (c == 2 || c == 4 || c == 6);
      exp_req  = (c == 1 || c == 3 || c == 5);
      exp_halt = (c >= 7);
      checks++; if (retire !== exp_ret) begin errors++; $display("[TB] FAIL basic_retire c=%0d: got %b expected %b", c, retire, exp_ret); end
      if (exp_ret) begin
        checks++; if (retire_pc !== 16'(c - 2)) begin errors++; $display("[TB] FAIL basic_retire_pc c=%0d: got %h expected %h", c, retire_pc, 16'(c - 2)); end
      end
      checks++; if (imem_req !== exp_req) begin errors++; $display("[TB] FAIL basic_req c=%0d: got %b expected %b", c, imem_req, exp_req); end
      checks++; if (halted !== exp_halt) begin errors++; $display("[TB] FAIL basic_halted c=%0d: got %b expected %b", c, halted, exp_halt); end
      if (c == 3) begin
        checks++; if (dut.rf[1] !== 16'd5) begin errors++; $display("[TB] FAIL basic_r1_early: got %h expected 0005", dut.rf[1]); end
      end
    end
    checks++; if (dut.rf[1] !== 16'd5) begin errors++; $display("[TB] FAIL basic_r1: got %h expected 0005", dut.rf[1]); end
    checks++; if (dut.rf[2] !== 16'd2) begin errors++; $display("[TB] FAIL basic_r2: got %h expected 0002", dut.rf[2]); end
  endtask

  // First fetch stalled for three cycles
  task automatic test_fetch_stall();
    clear_mem();
    mem[0] = enc_i(OP_ADDI, 0, 1, 7);
    imem_ack = 1'b0;
    reset_wide();
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c <= 4) begin
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0) begin errors++; $display("[TB] FAIL stall_hold c=%0d: got req=%b addr=%h expected req=1 addr=0000", c, imem_req, imem_addr); end
        checks++; if (retire !== 1'b0) begin errors++; $display("[TB] FAIL stall_retire c=%0d: got %b expected 0", c, retire); end
        checks++; if (dut.ir !== 16'h0) begin errors++; $display("[TB] FAIL stall_ir c=%0d: got %h expected 0000", c, dut.ir); end
      end else if (c == 5) begin
        checks++; if (retire !== 1'b1 || retire_pc !== 16'h0) begin errors++; $display("[TB] FAIL stall_retire_after_ack: got retire=%b pc=%h expected retire=1 pc=0000", retire, retire_pc); end
        checks++; if (dut.ir !== mem[0]) begin errors++; $display("[TB] FAIL stall_ir_capture: got %h expected %h", dut.ir, mem[0]); end
      end else begin
        checks++; if (dut.rf[1] !== 16'd7) begin errors++; $display("[TB] FAIL stall_r1: got %h expected 0007", dut.rf[1]); end
      end
      imem_ack = (c >= 4);
    end
  endtask

  // Branch chain: ADDI R4=-1, then BEQZ/BNEZ/BLTZ/BGEZ with R3=0, R4=0xFFFF
  task automatic test_branches();
    logic [15:0] exp_pc [8];
    int k;
    bit pend;
    exp_pc = '{16'h00, 16'h02, 16'h10, 16'h18, 16'h1A, 16'h20, 16'h1E, 16'h30};
    clear_mem();
    mem[0]  = enc_i(OP_ADDI, 0, 4, -1);
    mem[1]  = enc_b(OP_BEQZ, 0, 12);
    mem[8]  = enc_b(OP_BEQZ, 3, 6);
    mem[12] = enc_b(OP_BNEZ, 3, 6);
    mem[13] = enc_b(OP_BEQZ, 0, 4);
    mem[16] = enc_b(OP_BLTZ, 4, -4);
    mem[15] = enc_b(OP_BGEZ, 3, 16);
    imem_ack = 1'b1;
    reset_wide();
    k = 0;
    pend = 1'b0;
    for (int c = 1; c <= 40 && !halted; c++) begin
      tick();
      if (pend) begin
        checks++; if (imem_req !== 1'b1 || imem_addr !== exp_pc[k]) begin errors++; $display("[TB] FAIL branch_next_fetch: got req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, exp_pc[k]); end
        pend = 1'b0;
      end
      if (retire) begin
        checks++;
        if (k >= 8) begin
          errors++; $display("[TB] FAIL branch_extra_retire: got pc=%h expected no retire", retire_pc);
        end else begin
          if (retire_pc !== exp_pc[k]) begin errors++; $display("[TB] FAIL branch_retire_pc %0d: got %h expected %h", k, retire_pc, exp_pc[k]); end
          k++;
          pend = (k < 8);
        end
      end
    end
    checks++; if (k != 8) begin errors++; $display("[TB] FAIL branch_retire_count: got %0d expected 8", k); end
    checks++; if (halted !== 1'b1) begin errors++; $display("[TB] FAIL branch_halted: got %b expected 1", halted); end
  endtask

  // R-type functions with R1=0x00F0, R2=0x0FF0 built from immediates
  task automatic test_rtype();
    logic [15:0] prog [$];
    int c;
    prog = {};
    prog.push_back(enc_i(OP_ADDI, 0, 3, 9));
    prog.push_back(enc_i(OP_XORI, 0, 1, 15));
    repeat (4) prog.push_back(enc_r(1, 1, 1, 0));
    prog.push_back(enc_i(OP_XORI, 0, 2, 31));
    repeat (3) prog.push_back(enc_r(2, 2, 2, 0));
    prog.push_back(enc_i(OP_ADDI, 2, 2, 7));
    repeat (4) prog.push_back(enc_r(2, 2, 2, 0));
    prog.push_back(enc_r(1, 2, 5, 0));
    prog.push_back(enc_r(1, 2, 6, 1));
    prog.push_back(enc_r(1, 2, 7, 2));
    prog.push_back(enc_r(1, 2, 3, 3));
    prog.push_back(enc_i(OP_HALT, 0, 0, 0));
    clear_mem();
    for (int i = 0; i < prog.size(); i++) mem[i] = prog[i];
    reset_wide();
    c = 0;
    while (!halted && c < 500) begin
      imem_ack = ($urandom_range(0, 2) != 0);
      tick();
      c++;
    end
    checks++; if (halted !== 1'b1) begin errors++; $display("[TB] FAIL rtype_timeout: got halted=%b expected 1", halted); end
    checks++; if (dut.rf[1] !== 16'h00F0) begin errors++; $display("[TB] FAIL rtype_r1: got %h expected 00f0", dut.rf[1]); end
    checks++; if (dut.rf[2] !== 16'h0FF0) begin errors++; $display("[TB] FAIL rtype_r2: got %h expected 0ff0", dut.rf[2]); end
    checks++; if (dut.rf[5] !== 16'h10E0) begin errors++; $display("[TB] FAIL rtype_add: got %h expected 10e0", dut.rf[5]); end
    checks++; if (dut.rf[6] !== 16'h0F00) begin errors++; $display("[TB] FAIL rtype_sub: got %h expected 0f00", dut.rf[6]); end
    checks++; if (dut.rf[7] !== 16'h0F00) begin errors++; $display("[TB] FAIL rtype_xor: got %h expected 0f00", dut.rf[7]); end
    checks++; if (dut.rf[3] !== 16'h0000) begin errors++; $display("[TB] FAIL rtype_andn: got %h expected 0000", dut.rf[3]); end
  endtask

  // Illegal opcode 10101 at PC 6, then reset clears err
  task automatic test_illegal();
    logic exp_ret, exp_req, exp_err;
    clear_mem();
    mem[0] = enc_i(OP_ADDI, 0, 1, 3);
    mem[1] = enc_i(OP_NOP, 0, 0, 0);
    mem[2] = enc_i(OP_NOP, 0, 0, 0);
    mem[3] = {5'b10101, 3'd1, 3'd1, 3'd1, 2'd0};
    imem_ack = 1'b1;
    reset_wide();
    for (int c = 1; c <= 30; c++) begin
      tick();
      exp_ret = (c == 2 || c == 4 || c == 6);
      exp_req = (c == 1 || c == 3 || c == 5 || c == 7);
      exp_err = (c >= 9);
      checks++; if (retire !== exp_ret) begin errors++; $display("[TB] FAIL illegal_retire c=%0d: got %b expected %b", c, retire, exp_ret); end
      checks++; if (imem_req !== exp_req) begin errors++; $display("[TB] FAIL illegal_req c=%0d: got %b expected %b", c, imem_req, exp_req); end
      checks++; if (err !== exp_err) begin errors++; $display("[TB] FAIL illegal_err c=%0d: got %b expected %b", c, err, exp_err); end
      checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL illegal_halted c=%0d: got %b expected 0", c, halted); end
    end
    checks++; if (dut.rf[1] !== 16'd3) begin errors++; $display("[TB] FAIL illegal_r1: got %h expected 0003", dut.rf[1]); end
    checks++; if (imem_addr !== 16'h6) begin errors++; $display("[TB] FAIL illegal_pc: got %h expected 0006", imem_addr); end
    rst = 1'b1;
    tick();
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL illegal_reset_clears: got %b expected 0", err); end
    rst = 1'b0;
  endtask

  // Random programs with random ack stalls against the interpreter
  task automatic test_random();
    int c;
    for (int round = 0; round < 8; round++) begin
      clear_mem();
      for (int i = 0; i < 32; i++) mem[i] = rand_instr();
      model_reset();
      reset_wide();
      c = 0;
      while (!(halted || err) && c < 3000) begin
        imem_ack = ($urandom_range(0, 3) != 0);
        tick();
        c++;
        if (retire) begin
          checks++; if (retire_pc !== m_pc) begin errors++; $display("[TB] FAIL random_retire_pc r%0d: got %h expected %h", round, retire_pc, m_pc); end
          model_exec();
        end
      end
      checks++; if (c >= 3000) begin errors++; $display("[TB] FAIL random_timeout r%0d: got no halt/err expected termination", round); end
      if (!m_halt && !m_err) model_exec();
      checks++; if (halted !== m_halt) begin errors++; $display("[TB] FAIL random_halted r%0d: got %b expected %b", round, halted, m_halt); end
      checks++; if (err !== m_err) begin errors++; $display("[TB] FAIL random_err r%0d: got %b expected %b", round, err, m_err); end
      for (int i = 0; i < 8; i++) begin
        checks++; if (dut.rf[i] !== m_r[i]) begin errors++; $display("[TB] FAIL random_reg r%0d R%0d: got %h expected %h", round, i, dut.rf[i], m_r[i]); end
      end
    end
  endtask

  // DW=8/AW=8: sign extension, PC wrap, asynchronous reset mid-fetch
  task automatic test_narrow();
    logic [7:0] exp_pc [4];
    int k;
    bit pend;
    exp_pc = '{8'h00, 8'h02, 8'hFE, 8'h04};
    for (int i = 0; i < 128; i++) mem_b[i] = 16'h0000;
    mem_b[0]   = enc_i(OP_ADDI, 0, 1, -1);
    mem_b[1]   = enc_b(OP_BEQZ, 0, -6);
    mem_b[127] = enc_b(OP_BEQZ, 0, 4);
    ack_b = 1'b1;
    reset_narrow();
    k = 0;
    pend = 1'b0;
    for (int c = 1; c <= 30 && !halted_b; c++) begin
      tick();
      if (pend) begin
        checks++; if (req_b !== 1'b1 || addr_b !== exp_pc[k]) begin errors++; $display("[TB] FAIL narrow_next_fetch: got req=%b addr=%h expected req=1 addr=%h", req_b, addr_b, exp_pc[k]); end
        pend = 1'b0;
      end
      if (retire_b) begin
        checks++;
        if (k >= 4) begin
          errors++; $display("[TB] FAIL narrow_extra_retire: got pc=%h expected no retire", retire_pc_b);
        end else begin
          if (retire_pc_b !== exp_pc[k]) begin errors++; $display("[TB] FAIL narrow_retire_pc %0d: got %h expected %h", k, retire_pc_b, exp_pc[k]); end
          k++;
          pend = (k < 4);
        end
      end
    end
    checks++; if (k != 4) begin errors++; $display("[TB] FAIL narrow_retire_count: got %0d expected 4", k); end
    checks++; if (dut_b.rf[1] !== 8'hFF) begin errors++; $display("[TB] FAIL narrow_addi_neg: got %h expected ff", dut_b.rf[1]); end
    checks++; if (halted_b !== 1'b1) begin errors++; $display("[TB] FAIL narrow_halted: got %b expected 1", halted_b); end

    // Stall the second fetch, then assert reset between clock edges
    ack_b = 1'b1;
    reset_narrow();
    tick();
    tick();
    ack_b = 1'b0;
    tick();
    checks++; if (req_b !== 1'b1 || addr_b !== 8'h02) begin errors++; $display("[TB] FAIL narrow_stalled: got req=%b addr=%h expected req=1 addr=02", req_b, addr_b); end
    #2;
    rst_b = 1'b1;
    #1;
    checks++; if (req_b !== 1'b0) begin errors++; $display("[TB] FAIL narrow_async_req: got %b expected 0", req_b); end
    checks++; if (addr_b !== 8'h00) begin errors++; $display("[TB] FAIL narrow_async_addr: got %h expected 00", addr_b); end
    tick();
    rst_b = 1'b0;
    ack_b = 1'b1;
    tick();
    checks++; if (req_b !== 1'b1 || addr_b !== 8'h00) begin errors++; $display("[TB] FAIL narrow_restart: got req=%b addr=%h expected req=1 addr=00", req_b, addr_b); end
  endtask

  initial begin
    rst      = 1'b1;
    rst_b    = 1'b1;
    imem_ack = 1'b0;
    ack_b    = 1'b0;
    for (int i = 0; i < 128; i++) mem_b[i] = 16'h0000;
    test_reset();
    test_basic();
    test_fetch_stall();
    test_branches();
    test_rtype();
    test_illegal();
    test_random();
    test_narrow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/proc_mc.md
# proc_mc

Multi-cycle, parametrised successor to the single-cycle test processor. Fetches 16-bit instructions over a request/acknowledge instruction-memory port and executes them through a FETCH/EXEC state machine. It owns an 8-entry register file of configurable data width and implements a wider ALU and branch set. Halt, illegal-instruction and retire information are exported for the testbench.

## Interface
- DW, 16: data/register width in bits, 8..32; immediates sign-extend to DW
- AW, 16: PC and instruction address width, 8..32
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- imem_req  out  1  instruction fetch request
- imem_addr  out  AW  fetch address, equals PC
- imem_ack  in  1  memory accepts request; imem_rdata valid the same cycle
- imem_rdata  in  16  instruction word
- retire  out  1  one-cycle pulse: instruction at retire_pc completed EXEC
- retire_pc  out  AW  PC of retiring instruction
- halted  out  1  sticky, HALT executed
- err  out  1  sticky, illegal instruction decoded

## Operation
- State: PC (AW), IR (16), R0..R7 (DW each; R0 is ordinary), FSM {FETCH, EXEC, HALT, ERR}.
- Reset: FSM=FETCH, PC=0, IR=0, all registers 0. Outputs: imem_req=0 during reset, then 1. Also during reset: retire=0, halted=0, err=0, imem_addr=0.
- FETCH: imem_req=1, imem_addr=PC, held stable until a cycle with imem_ack=1. On that edge IR<=imem_rdata and FSM<=EXEC.
- EXEC: imem_req=0. The instruction executes in one cycle from IR. Fields: op=IR[15:11], rs=IR[10:8], rt=IR[7:5], imm5=IR[4:0], imm8=IR[7:0], fn=IR[1:0].
- 00000 HALT: FSM<=HALT, PC unchanged, no write.
- 00001 NOP.
- 01000 ADDI: R[rt] <= R[rs] + sext(imm5).
- 01010 XORI: R[rt] <= R[rs] ^ zext(imm5).
- 11011 R-type: destination R[IR[4:2]], chosen by fn.
  - fn=00: rs+rt
  - fn=01: rt−rs
  - fn=10: rs^rt
  - fn=11: rs & ~rt
- 01100 BEQZ taken if R[rs]==0.
- 01101 BNEZ taken if R[rs]!=0.
- 01110 BLTZ taken if R[rs][DW-1]==1.
- 01111 BGEZ taken if R[rs][DW-1]==0.
- Any other opcode: FSM<=ERR, no register write, PC unchanged.
- Next PC: PC+2. For a taken branch: PC+2+sext(imm8). All modulo 2^AW, with no fault on wrap.
- Arithmetic is modulo 2^DW. No flags and no overflow detection.
- Legal non-halt EXEC: register write (if any) and PC update on the same edge; FSM<=FETCH; retire=1 that cycle with retire_pc=PC. HALT also pulses retire. Illegal instructions do not retire.
- HALT and ERR are terminal until reset. In both: imem_req=0, no writes, PC frozen. halted=1 in HALT; err=1 in ERR.

## Timing
- Every output is a function of registered state only. imem_rdata/imem_ack have no combinational path to any output.
- Minimum 2 cycles per instruction (FETCH with same-cycle ack, then EXEC). Each cycle of ack-low stall adds one.
- A register written in EXEC of instruction N is read by EXEC of N+1 with no hazard, since the write precedes N+1's EXEC.
- imem_ack while imem_req=0 is ignored.
- Reset asserted mid-fetch: imem_req drops immediately (asynchronous) and all state clears. Fetch restarts from address 0 on the first edge after deassertion.
- halted/err assert the cycle after the deciding EXEC and stay high.

## Test plan
- Reset then ADDI R1,R0,5; ADDI R2,R1,-3; HALT with ack always 1 -> R1=5 then R2=2. Retire pulses at PC 0, 2, 4 on cycles 2, 4, 6. halted=1 from cycle 7; imem_req stays 0.
- Fetch stall: ack low for 3 cycles on the first fetch -> imem_addr=0 held stable for 4 cycles, IR captured only on the ack cycle, retire 1 cycle later.
- Branches with R3=0, R4=0xFFFF (DW=16):
  - BEQZ R3,+6 at PC 0x10 -> next fetch 0x18.
  - BNEZ R3,+6 -> next fetch 0x12.
  - BLTZ R4,-4 at 0x20 -> next fetch 0x1E.
- R-type with R1=0x00F0, R2=0x0FF0:
  - fn=00 -> 0x10E0
  - fn=01 -> 0x0F00
  - fn=10 -> 0x0F00
  - fn=11 -> 0x0000
- Illegal opcode 10101 at PC 6 -> err=1 next cycle, no retire, registers unchanged, imem_req=0 permanently. A subsequent reset clears err.
- DW=8, AW=8: ADDI R1,R0,-1 gives 0xFF. BEQZ at PC 0xFE with R0=0 and imm=+4 -> next fetch 0x04 (PC wrap). Reset asserted during a stalled fetch -> imem_req falls in the same cycle.
